// File: rtl/br_sched_pkg.sv
// rtl/br_sched_pkg.sv - shared types and branch function codes for br_sched and brcond
package br_sched_pkg;

    localparam int XLEN     = 32;
    localparam int BR_TAG_W = 5;

    localparam logic [2:0] BEQ    = 3'd0;
    localparam logic [2:0] BNE    = 3'd1;
    localparam logic [2:0] UNCOND = 3'd2;
    localparam logic [2:0] BLT    = 3'd4;
    localparam logic [2:0] BGE    = 3'd5;
    localparam logic [2:0] BLTU   = 3'd6;
    localparam logic [2:0] BGEU   = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     imm;
        logic [2:0]          func;
        logic                is_jalr;
        logic                pred_taken;
        logic [XLEN-1:0]     pred_target;
        logic [BR_TAG_W-1:0] tag;
    } br_req_t;

    typedef struct packed {
        logic [BR_TAG_W-1:0] tag;
        logic                taken;
        logic [XLEN-1:0]     target;
        logic [XLEN-1:0]     link;
        logic                mispredict;
    } br_res_t;

endpackage

// File: rtl/br_rr_arb.sv
// rtl/br_rr_arb.sv - round-robin arbiter with one-hot grant and rotating pointer
module br_rr_arb #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_nxt;
    logic [PW-1:0] w_idx [N];
    logic          w_hit;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            w_idx[k] = PW'((int'(r_ptr) + k) % N);
        end
    end

    // First valid port at or after the pointer wins; pointer moves just past it.
    always_comb begin
        o_gnt = '0;
        w_hit = 1'b0;
        w_nxt = r_ptr;
        for (int k = 0; k < N; k++) begin
            if (i_en && !w_hit && i_req[w_idx[k]]) begin
                w_hit           = 1'b1;
                o_gnt[w_idx[k]] = 1'b1;
                w_nxt           = PW'((int'(w_idx[k]) + 1) % N);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_hit) begin
            r_ptr <= w_nxt;
        end
    end

endmodule

// File: rtl/brcond.sv
// rtl/brcond.sv - branch condition comparator
module brcond
    import br_sched_pkg::*;
(
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [2:0]      i_func,
    output logic            o_cond
);

    always_comb begin
        o_cond = 1'b0;
        case (i_func)
            BEQ:     o_cond = (i_rs1 == i_rs2);
            BNE:     o_cond = (i_rs1 != i_rs2);
            BLT:     o_cond = ($signed(i_rs1) < $signed(i_rs2));
            BGE:     o_cond = ($signed(i_rs1) >= $signed(i_rs2));
            BLTU:    o_cond = (i_rs1 < i_rs2);
            BGEU:    o_cond = (i_rs1 >= i_rs2);
            UNCOND:  o_cond = 1'b1;
            default: o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/br_sched.sv
// rtl/br_sched.sv - branch-resolution scheduler; BR_SCHED_STATS_EN adds handshake counters
module br_sched
    import br_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = BR_TAG_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         squash,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  br_req_t [NUM_REQ-1:0]        req_pkt,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         out_valid,
    input  logic                         out_ready,
    output br_res_t                      out_pkt
`ifdef BR_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_resolved,
    output logic [31:0]                  stat_mispred
`endif
);

    logic               r_s1_v;
    logic               r_s2_v;
    br_req_t            r_s1;
    br_res_t            r_s2;

    logic               w_s2_load;
    logic               w_s1_adv;
    logic               w_arb_en;
    logic [NUM_REQ-1:0] w_gnt;
    br_req_t            w_sel;
    logic               w_cond;
    logic [XLEN-1:0]    w_target;
    logic [TAG_W-1:0]   w_tag;
    br_res_t            w_res;

    assign w_s2_load = !r_s2_v || out_ready;
    assign w_s1_adv  = !r_s1_v || w_s2_load;
    assign w_arb_en  = w_s1_adv && !squash && !reset;
    assign req_ready = w_gnt;

    br_rr_arb #(.N(NUM_REQ)) u_arb (
        .clock (clock),
        .reset (reset),
        .i_req (req_valid),
        .i_en  (w_arb_en),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) w_sel = req_pkt[i];
        end
    end

    brcond u_brcond (
        .i_rs1  (r_s1.rs1),
        .i_rs2  (r_s1.rs2),
        .i_func (r_s1.func),
        .o_cond (w_cond)
    );

    assign w_tag    = r_s1.tag;
    assign w_target = r_s1.is_jalr ? ((r_s1.rs1 + r_s1.imm) & ~XLEN'(1))
                                   : (r_s1.pc + r_s1.imm);

    always_comb begin
        w_res            = '0;
        w_res.tag        = w_tag;
        w_res.taken      = w_cond;
        w_res.target     = w_target;
        w_res.link       = r_s1.pc + XLEN'(4);
        w_res.mispredict = (w_cond != r_s1.pred_taken) ||
                           (w_cond && (w_target != r_s1.pred_target));
    end

    // S1 captures only on an accepting edge; S2 loads whenever it drains or is empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_v <= 1'b0;
            r_s1   <= '0;
            r_s2_v <= 1'b0;
            r_s2   <= '0;
        end else if (squash) begin
            r_s1_v <= 1'b0;
            r_s2_v <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_v <= |w_gnt;
                if (|w_gnt) r_s1 <= w_sel;
            end
            if (w_s2_load) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) r_s2 <= w_res;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign out_pkt   = r_s2;

`ifdef BR_SCHED_STATS_EN
    logic [31:0] r_stat_res;
    logic [31:0] r_stat_mis;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stat_res <= '0;
            r_stat_mis <= '0;
        end else if (r_s2_v && out_ready && !squash) begin
            r_stat_res <= r_stat_res + 32'd1;
            if (r_s2.mispredict) r_stat_mis <= r_stat_mis + 32'd1;
        end
    end

    assign stat_resolved = r_stat_res;
    assign stat_mispred  = r_stat_mis;
`endif

endmodule

// File: tb/tb_br_sched.sv
// tb/tb_br_sched.sv - self-checking bench for br_sched (vector table, directed sequences, random vs model)
module tb_br_sched;
    import br_sched_pkg::*;

    localparam int N = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic              squash;
    logic              out_ready;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    br_req_t [N-1:0]   req_pkt;
    logic              out_valid;
    br_res_t           out_pkt;
`ifdef BR_SCHED_STATS_EN
    logic [31:0]       stat_resolved;
    logic [31:0]       stat_mispred;
`endif

    br_sched #(.NUM_REQ(N), .TAG_W(5)) dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .req_valid (req_valid),
        .req_pkt   (req_pkt),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pkt   (out_pkt)
`ifdef BR_SCHED_STATS_EN
        ,
        .stat_resolved (stat_resolved),
        .stat_mispred  (stat_mispred)
`endif
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic br_res_t ref_resolve(input br_req_t r);
        br_res_t     res;
        logic        c;
        logic [31:0] t;
        case (r.func)
            BEQ:     c = (r.rs1 == r.rs2);
            BNE:     c = (r.rs1 != r.rs2);
            BLT:     c = ($signed(r.rs1) < $signed(r.rs2));
            BGE:     c = !($signed(r.rs1) < $signed(r.rs2));
            BLTU:    c = (r.rs1 < r.rs2);
            BGEU:    c = !(r.rs1 < r.rs2);
            UNCOND:  c = 1'b1;
            default: c = 1'b0;
        endcase
        t = r.is_jalr ? ((r.rs1 + r.imm) & 32'hFFFF_FFFE) : (r.pc + r.imm);
        res.tag        = r.tag;
        res.taken      = c;
        res.target     = t;
        res.link       = r.pc + 32'd4;
        res.mispredict = c ? (!r.pred_taken || (t != r.pred_target)) : r.pred_taken;
        return res;
    endfunction

    function automatic br_req_t rand_pkt();
        br_req_t p;
        p.rs1         = $urandom;
        p.rs2         = ($urandom_range(0, 2) == 0) ? p.rs1 : $urandom;
        p.pc          = $urandom;
        p.imm         = $urandom;
        p.func        = 3'($urandom_range(0, 7));
        p.is_jalr     = ($urandom_range(0, 3) == 0);
        p.pred_taken  = 1'($urandom_range(0, 1));
        p.pred_target = ($urandom_range(0, 1) == 0) ? (p.pc + p.imm) : $urandom;
        p.tag         = 5'($urandom);
        return p;
    endfunction

    function automatic br_req_t mk_pkt(input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] pc, input logic [31:0] imm,
                                       input logic [2:0] func, input logic jalr,
                                       input logic pt, input logic [31:0] ptgt,
                                       input logic [4:0] tag);
        br_req_t p;
        p.rs1 = rs1; p.rs2 = rs2; p.pc = pc; p.imm = imm; p.func = func;
        p.is_jalr = jalr; p.pred_taken = pt; p.pred_target = ptgt; p.tag = tag;
        return p;
    endfunction

    typedef struct {
        logic [31:0] rs1, rs2, pc, imm;
        logic [2:0]  func;
        logic        jalr, pt;
        logic [31:0] ptgt;
        logic        e_taken;
        logic [31:0] e_target, e_link;
        logic        e_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; squash = 1'b0; req_valid = '0; out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_one(input vec_t v, input logic [4:0] tag);
        @(negedge clock);
        req_valid  = 2'b01;
        out_ready  = 1'b1;
        req_pkt[0] = mk_pkt(v.rs1, v.rs2, v.pc, v.imm, v.func, v.jalr, v.pt, v.ptgt, tag);
        #1 check("vec_ready", req_ready, 2'b01);
        @(posedge clock);
        #1;
        req_valid  = '0;
        req_pkt[0] = rand_pkt();
        check("vec_lat_lo", out_valid, 1'b0);
        @(posedge clock);
        #1;
        check("vec_valid", out_valid, 1'b1);
        check("vec_tag", out_pkt.tag, tag);
        check("vec_taken", out_pkt.taken, v.e_taken);
        check("vec_target", out_pkt.target, v.e_target);
        check("vec_link", out_pkt.link, v.e_link);
        check("vec_mis", out_pkt.mispredict, v.e_mis);
    endtask

    typedef struct {
        br_res_t r;
        bit      vis;
    } mitem_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [4:0] exp_tag [$];
        mitem_t     mq [$];
        int         mptr;
        int         m_res;
        int         m_mis;

        vecs[0] = '{32'd5, 32'd5, 32'h100, 32'h20, BEQ, 1'b0, 1'b0, 32'h0,
                    1'b1, 32'h120, 32'h104, 1'b1};
        vecs[1] = '{32'h1003, 32'h0, 32'h200, 32'h4, UNCOND, 1'b1, 1'b1, 32'h1006,
                    1'b1, 32'h1006, 32'h204, 1'b0};
        vecs[2] = '{32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, BLT, 1'b0, 1'b1, 32'h310,
                    1'b1, 32'h310, 32'h304, 1'b0};
        vecs[3] = '{32'hFFFF_FFFF, 32'd1, 32'h300, 32'h10, BLTU, 1'b0, 1'b1, 32'h310,
                    1'b0, 32'h310, 32'h304, 1'b1};
        vecs[4] = '{32'd7, 32'd7, 32'hFFFF_FFFC, 32'h8, BNE, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h4, 32'h0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'd0, 32'h400, 32'hFFFF_FFF0, BGE, 1'b0, 1'b0, 32'h0,
                    1'b0, 32'h3F0, 32'h404, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'd0, 32'h400, 32'hFFFF_FFF0, BGEU, 1'b0, 1'b1, 32'h3F4,
                    1'b1, 32'h3F0, 32'h404, 1'b1};
        vecs[7] = '{32'd1, 32'd1, 32'h500, 32'h8, 3'd3, 1'b0, 1'b1, 32'h508,
                    1'b0, 32'h508, 32'h504, 1'b1};

        reset = 1'b1; squash = 1'b1; out_ready = 1'b1; req_valid = 2'b11;
        req_pkt[0] = rand_pkt(); req_pkt[1] = rand_pkt();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_ready", req_ready, 2'b00);
        check("rst_valid", out_valid, 1'b0);
        check("rst_pkt", out_pkt, '0);
`ifdef BR_SCHED_STATS_EN
        check("rst_stat_res", stat_resolved, 32'd0);
        check("rst_stat_mis", stat_mispred, 32'd0);
`endif
        reset = 1'b0; squash = 1'b0; req_valid = '0;

        for (int i = 0; i < 8; i++) send_one(vecs[i], 5'(i));

        // Both ports saturated: grants alternate, one result per cycle.
        do_reset();
        exp_tag.delete();
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            out_ready  = 1'b1;
            req_valid  = (k < 6) ? 2'b11 : 2'b00;
            req_pkt[0] = rand_pkt(); req_pkt[0].tag = 5'(10 + k);
            req_pkt[1] = rand_pkt(); req_pkt[1].tag = 5'(20 + k);
            #1;
            check("alt_ready", req_ready, (k >= 6) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10));
            if (k < 6) exp_tag.push_back((k % 2 == 0) ? 5'(10 + k) : 5'(20 + k));
            check("alt_valid", out_valid, (k >= 2 && k < 8) ? 1'b1 : 1'b0);
            if (k >= 2 && k < 8) check("alt_tag", out_pkt.tag, exp_tag[k - 2]);
        end

        // Backpressure: two buffered, no further grants, ordered drain.
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(negedge clock);
            out_ready  = (k >= 6);
            req_valid  = (k < 6) ? 2'b11 : 2'b00;
            req_pkt[0] = rand_pkt(); req_pkt[0].tag = 5'(k);
            req_pkt[1] = rand_pkt(); req_pkt[1].tag = 5'(16 + k);
            #1;
            check("bp_ready", req_ready, (k == 0) ? 2'b01 : ((k == 1) ? 2'b10 : 2'b00));
            check("bp_valid", out_valid, (k >= 2 && k <= 7) ? 1'b1 : 1'b0);
            if (k >= 2 && k <= 6) check("bp_tag_a", out_pkt.tag, 5'd0);
            if (k == 7) check("bp_tag_b", out_pkt.tag, 5'd17);
        end

        // Squash with S1 and S2 full, handshake in the squash cycle discarded.
        do_reset();
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            squash    = (k == 2);
            out_ready = (k >= 2);
            req_valid = (k < 2) ? 2'b11 : ((k == 3) ? 2'b01 : 2'b00);
            req_pkt[0] = mk_pkt(32'd3, 32'd3, 32'h600, 32'h40, BEQ, 1'b0, 1'b0, 32'h0,
                                (k == 3) ? 5'h1A : 5'(k));
            req_pkt[1] = mk_pkt(32'd3, 32'd3, 32'h700, 32'h40, BEQ, 1'b0, 1'b0, 32'h0, 5'(8 + k));
            #1;
            if (k == 2) begin
                check("sq_valid_during", out_valid, 1'b1);
                check("sq_ready_during", req_ready, 2'b00);
            end
            if (k == 3) begin
                check("sq_valid_after", out_valid, 1'b0);
                check("sq_regrant", req_ready, 2'b01);
            end
            if (k == 4) check("sq_lat_lo", out_valid, 1'b0);
            if (k == 5) begin
                check("sq_valid_ret", out_valid, 1'b1);
                check("sq_tag_ret", out_pkt.tag, 5'h1A);
                check("sq_target_ret", out_pkt.target, 32'h640);
            end
`ifdef BR_SCHED_STATS_EN
            if (k == 6) begin
                check("sq_stat_res", stat_resolved, 32'd1);
                check("sq_stat_mis", stat_mispred, 32'd1);
            end
`endif
        end

        // Randomised traffic against the elastic-buffer reference model.
        do_reset();
        mq.delete();
        mptr  = 0;
        m_res = 0;
        m_mis = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit exp_ov;
            bit hs;
            bit can_acc;
            int g;
            @(negedge clock);
            req_valid  = 2'($urandom_range(0, 3));
            req_pkt[0] = rand_pkt();
            req_pkt[1] = rand_pkt();
            out_ready  = ($urandom_range(0, 3) != 0);
            squash     = ($urandom_range(0, 49) == 0);
            #1;
            exp_ov = (mq.size() > 0) && mq[0].vis;
            check("rnd_valid", out_valid, exp_ov);
            if (exp_ov) check("rnd_pkt", out_pkt, mq[0].r);
`ifdef BR_SCHED_STATS_EN
            check("rnd_stat_res", stat_resolved, 32'(m_res));
            check("rnd_stat_mis", stat_mispred, 32'(m_mis));
`endif
            hs      = exp_ov && out_ready;
            can_acc = (mq.size() - (hs ? 1 : 0)) < 2;
            g       = -1;
            if (!squash && can_acc) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
                end
            end
            check("rnd_ready", req_ready, (g >= 0) ? (2'b01 << g) : 2'b00);
            if (hs && !squash) begin
                m_res++;
                if (mq[0].r.mispredict) m_mis++;
            end
            if (squash) begin
                mq.delete();
            end else begin
                if (hs) void'(mq.pop_front());
                foreach (mq[j]) mq[j].vis = 1'b1;
                if (g >= 0) begin
                    mq.push_back('{ref_resolve(req_pkt[g]), 1'b0});
                    mptr = (g + 1) % N;
                end
            end
        end

        @(negedge clock);
        req_valid = '0; squash = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
